// File: rtl/clken_gen.sv
// Multi-channel clock-enable divider: per-channel square-wave levels with rise/fall enables, plus LOAD-driven phase alignment.
// Latency: CLK_OUT registered (updates the edge after EN_P/EN_N); SYNC_DONE one cycle after the aligning tick. No backpressure.
module clken_gen #(
  parameter int                  CHANNELS    = 4,
  parameter int                  DIV_W       = 8,
  parameter logic [CHANNELS-1:0] RESET_LEVEL = '0
) (
  input  logic                      CLK,
  input  logic                      nRESETP,
  input  logic                      CLK_EN_BASE,
  input  logic                      TURBO,
  input  logic [CHANNELS*DIV_W-1:0] DIV_SEL,
  input  logic [CHANNELS-1:0]       HOLD,
  input  logic                      LOAD,
  output logic [CHANNELS-1:0]       CLK_OUT,
  output logic [CHANNELS-1:0]       EN_P,
  output logic [CHANNELS-1:0]       EN_N,
  output logic                      SYNC_DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   tick;
  logic   align_now;
  logic   sync_done_q;

  assign tick      = CLK_EN_BASE | TURBO;
  assign align_now = (state_q == ARMED) & tick;

  always_ff @(posedge CLK or negedge nRESETP) begin
    if (!nRESETP) begin
      state_q     <= IDLE;
      sync_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_done_q <= align_now;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (LOAD) state_d = ARMED;
      ARMED:   if (tick) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign SYNC_DONE = sync_done_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] ra_q;
    logic             lvl_q;
    logic [DIV_W-1:0] ratio;
    logic             at_end;
    logic             step;

    assign ratio  = DIV_SEL[i*DIV_W +: DIV_W];
    assign at_end = (cnt_q == ra_q);
    assign step   = tick & ~HOLD[i] & ~align_now;

    // Ratio reloads only when the high phase ends, so periods are never cut or stretched.
    always_ff @(posedge CLK or negedge nRESETP) begin
      if (!nRESETP) begin
        cnt_q <= '0;
        lvl_q <= RESET_LEVEL[i];
        ra_q  <= '0;
      end else if (align_now) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
        ra_q  <= ratio;
      end else if (step) begin
        if (at_end) begin
          cnt_q <= '0;
          lvl_q <= ~lvl_q;
          if (lvl_q) ra_q <= ratio;
        end else begin
          cnt_q <= cnt_q + DIV_W'(1);
        end
      end
    end

    assign CLK_OUT[i] = lvl_q;
    assign EN_P[i]    = nRESETP & step & at_end & ~lvl_q;
    assign EN_N[i]    = nRESETP & step & at_end &  lvl_q;
  end

endmodule

// File: tb/tb_clken_gen.sv
// Randomized bench for clken_gen against a tick-level behavioural model of the divider channels and alignment sequence.
module tb_clken_gen;
  localparam int CH = 4;
  localparam int DW = 8;
  localparam logic [CH-1:0] RST_LVL = 4'b0101;

  logic            CLK = 1'b0;
  logic            nRESETP;
  logic            CLK_EN_BASE;
  logic            TURBO;
  logic [CH*DW-1:0] DIV_SEL;
  logic [CH-1:0]   HOLD;
  logic            LOAD;
  logic [CH-1:0]   CLK_OUT, EN_P, EN_N;
  logic            SYNC_DONE;

  clken_gen #(.CHANNELS(CH), .DIV_W(DW), .RESET_LEVEL(RST_LVL)) dut (
    .CLK(CLK), .nRESETP(nRESETP), .CLK_EN_BASE(CLK_EN_BASE), .TURBO(TURBO),
    .DIV_SEL(DIV_SEL), .HOLD(HOLD), .LOAD(LOAD), .CLK_OUT(CLK_OUT),
    .EN_P(EN_P), .EN_N(EN_N), .SYNC_DONE(SYNC_DONE)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: phase count within the half-period, level, active ratio, alignment phase.
  int m_cnt [CH];
  int m_lvl [CH];
  int m_ra  [CH];
  int m_phase;   // 0 waiting for LOAD, 1 waiting for tick, 2 reporting
  int m_sync;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int field(input int ch);
    logic [CH*DW-1:0] v;
    v = DIV_SEL;
    return int'(v[ch*DW +: DW]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0;
      m_lvl[i] = int'(RST_LVL[i]);
      m_ra[i]  = 0;
    end
    m_phase = 0;
    m_sync  = 0;
  endtask

  task automatic model_edge();
    int tick, align;
    tick  = (CLK_EN_BASE || TURBO) ? 1 : 0;
    align = (m_phase == 1 && tick == 1) ? 1 : 0;
    for (int i = 0; i < CH; i++) begin
      if (align == 1) begin
        m_cnt[i] = 0;
        m_lvl[i] = 0;
        m_ra[i]  = field(i);
      end else if (tick == 1 && !HOLD[i]) begin
        if (m_cnt[i] < m_ra[i]) m_cnt[i] = m_cnt[i] + 1;
        else begin
          if (m_lvl[i] == 1) m_ra[i] = field(i);
          m_lvl[i] = 1 - m_lvl[i];
          m_cnt[i] = 0;
        end
      end
    end
    m_sync = align;
    case (m_phase)
      0: if (LOAD) m_phase = 1;
      1: if (tick == 1) m_phase = 2;
      default: m_phase = 0;
    endcase
  endtask

  // Inputs were set at the negedge; compare just after, then advance the model at the posedge.
  task automatic run_cycle();
    logic [CH-1:0] e_out, e_p, e_n;
    int tick, align;
    #1;
    if (!nRESETP) model_reset();
    tick  = (CLK_EN_BASE || TURBO) ? 1 : 0;
    align = (m_phase == 1 && tick == 1) ? 1 : 0;
    for (int i = 0; i < CH; i++) begin
      e_out[i] = (m_lvl[i] == 1);
      e_p[i]   = nRESETP && tick == 1 && !HOLD[i] && align == 0 && m_cnt[i] == m_ra[i] && m_lvl[i] == 0;
      e_n[i]   = nRESETP && tick == 1 && !HOLD[i] && align == 0 && m_cnt[i] == m_ra[i] && m_lvl[i] == 1;
    end
    check("clk_out",   32'(CLK_OUT),   32'(e_out));
    check("en_p",      32'(EN_P),      32'(e_p));
    check("en_n",      32'(EN_N),      32'(e_n));
    check("en_overlap", 32'(EN_P & EN_N), 32'd0);
    check("sync_done", 32'(SYNC_DONE), 32'(m_sync));
    @(posedge CLK);
    if (nRESETP) model_edge();
    @(negedge CLK);
  endtask

  initial begin
    nRESETP = 1'b0; CLK_EN_BASE = 1'b0; TURBO = 1'b0;
    DIV_SEL = '0; HOLD = '0; LOAD = 1'b0;
    model_reset();
    @(negedge CLK);
    run_cycle();
    run_cycle();
    nRESETP = 1'b1;

    // Base tick every 4th cycle, ratio 0: every output toggles each tick.
    for (int c = 0; c < 40; c++) begin
      CLK_EN_BASE = (c % 4 == 3);
      run_cycle();
    end

    // Constant tick, ratio change on channel 1 during the high phase.
    CLK_EN_BASE = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c == 3) DIV_SEL[1*DW +: DW] = 8'd2;
      run_cycle();
    end

    // Alignment with a late tick and a repeated LOAD while armed.
    DIV_SEL = {8'd3, 8'd1, 8'd2, 8'd0};
    for (int c = 0; c < 12; c++) begin
      CLK_EN_BASE = (c < 5);
      LOAD = (c == 5 || c == 7);
      if (c >= 8) CLK_EN_BASE = (c == 8);
      run_cycle();
    end
    LOAD = 1'b0;

    // Reset while armed abandons alignment.
    LOAD = 1'b1; CLK_EN_BASE = 1'b0; run_cycle();
    LOAD = 1'b0; run_cycle();
    nRESETP = 1'b0; run_cycle();
    nRESETP = 1'b1; CLK_EN_BASE = 1'b1; run_cycle(); run_cycle();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      CLK_EN_BASE = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) TURBO = ~TURBO;
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 19) == 0) HOLD[i] = ~HOLD[i];
      if ($urandom_range(0, 14) == 0)
        DIV_SEL[$urandom_range(0, CH-1)*DW +: DW] = 8'($urandom_range(0, 6));
      LOAD = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 399) == 0) nRESETP = 1'b0;
      else if (!nRESETP && $urandom_range(0, 1) == 0) nRESETP = 1'b1;
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
